// File: rtl/dram_bank_burst.sv
// dram_bank_burst: single DRAM bank with ACT/PRE/RD/WR command FSM and wrapped BL8/BC4 burst engine
module dram_bank_burst #(
  parameter int CHWIDTH      = 5,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int RL           = 4,
  parameter int WL           = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd,
  input  logic                    bc4,
  input  logic [CHWIDTH-1:0]      row,
  input  logic [COLWIDTH-1:0]     column,
  output logic                    cmd_ready,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  output logic                    dq_valid,
  output logic                    row_open,
  output logic [CHWIDTH-1:0]      open_row,
  output logic                    cmd_err
);
  localparam int ROWS = 2**CHWIDTH;
  localparam int COLS = 2**COLWIDTH;
  localparam int CW   = $clog2((RL > WL ? RL : WL) + BL + 2) + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, RD_BURST, WR_BURST} state_t;
  logic [DEVICE_WIDTH-1:0] mem [ROWS*COLS];
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, nidx, blen, bnlen;
  logic [COLWIDTH-1:0]     col_q, col_d, bcol;
  logic                    bc4_q, bc4_d, bbc4;
  logic [CHWIDTH-1:0]      open_row_q, open_row_d;
  logic [DEVICE_WIDTH-1:0] dqout_q, dqout_d;
  logic                    ready_q, dq_valid_q, row_open_q, err_q, err_d;
  logic                    accept, rd_ok, rd_fire, wr_fire;
  function automatic logic [COLWIDTH-1:0] wrap_col(input logic [COLWIDTH-1:0] c, input logic b4,
                                                   input logic [CW-1:0] k);
    logic [COLWIDTH-1:0] m;
    m = b4 ? COLWIDTH'(3) : COLWIDTH'(BL - 1);
    return (c & ~m) | ((c + COLWIDTH'(k)) & m);
  endfunction
  assign accept = cmd_valid && ready_q;
  assign rd_ok  = accept && cmd == 3'd3 && state_q == ACTIVE;
  assign blen   = bc4_q ? CW'(4) : CW'(BL);
  // With RL==1 the first read beat must be fetched on the accept edge itself
  assign nidx   = rd_ok ? CW'(1) : cnt_q + CW'(1);
  assign bcol   = rd_ok ? column : col_q;
  assign bbc4   = rd_ok ? bc4 : bc4_q;
  assign bnlen  = bbc4 ? CW'(4) : CW'(BL);
  assign rd_fire = (state_q == RD_BURST || rd_ok) && nidx >= CW'(RL) && nidx < CW'(RL) + bnlen;
  assign wr_fire = state_q == WR_BURST && cnt_q >= CW'(WL) && cnt_q < CW'(WL) + blen;
  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == RD_BURST || state_q == WR_BURST) ? cnt_q + CW'(1) : '0;
    col_d      = col_q;
    bc4_d      = bc4_q;
    open_row_d = open_row_q;
    err_d      = 1'b0;
    if (accept && cmd == 3'd1) begin
      if (state_q == IDLE) begin
        state_d    = ACTIVE;
        open_row_d = row;
      end else err_d = 1'b1;
    end else if (accept && cmd == 3'd2) begin
      state_d = IDLE;
    end else if (accept && (cmd == 3'd3 || cmd == 3'd4)) begin
      if (state_q == IDLE) err_d = 1'b1;
      else begin
        state_d = cmd == 3'd3 ? RD_BURST : WR_BURST;
        cnt_d   = CW'(1);
        col_d   = column;
        bc4_d   = bc4;
      end
    end
    if (state_q == RD_BURST && cnt_q == CW'(RL) + blen - CW'(1)) state_d = ACTIVE;
    if (state_q == WR_BURST && cnt_q == CW'(WL) + blen - CW'(1)) state_d = ACTIVE;
    dqout_d = rd_fire ? mem[{open_row_q, wrap_col(bcol, bbc4, nidx - CW'(RL))}] : dqout_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      col_q      <= '0;
      bc4_q      <= 1'b0;
      open_row_q <= '0;
      dqout_q    <= '0;
      dq_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      row_open_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      bc4_q      <= bc4_d;
      open_row_q <= open_row_d;
      dqout_q    <= dqout_d;
      dq_valid_q <= rd_fire;
      ready_q    <= state_d == IDLE || state_d == ACTIVE;
      row_open_q <= state_d != IDLE;
      err_q      <= err_d;
    end
  end
  // Storage has no reset so contents survive a reset
  always_ff @(posedge clk)
    if (wr_fire) mem[{open_row_q, wrap_col(col_q, bc4_q, cnt_q - CW'(WL))}] <= dqin;
  assign cmd_ready = ready_q;
  assign dqout     = dqout_q;
  assign dq_valid  = dq_valid_q;
  assign row_open  = row_open_q;
  assign open_row  = open_row_q;
  assign cmd_err   = err_q;
endmodule

// File: tb/tb_dram_bank_burst.sv
// tb_dram_bank_burst: scoreboard bench for dram_bank_burst with an array-based bank model
module tb_dram_bank_burst;
  localparam int BL = 8, RL = 4, WL = 3;
  logic clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, bc4 = 1'b0;
  logic [2:0] cmd = '0;
  logic [4:0] row = '0, open_row;
  logic [9:0] column = '0;
  logic [3:0] dqin = '0, dqout;
  logic cmd_ready, dq_valid, row_open, cmd_err;
  typedef struct {int c; logic [3:0] d;} beat_t;
  beat_t exq[$];
  logic [3:0] mm [int];
  logic [3:0] wd [8];
  logic [3:0] last_dq = '0;
  bit mopen = 0;
  int morow = 0, cyc = 0, errs = 0, checks = 0;
  dram_bank_burst dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .bc4(bc4), .row(row),
    .column(column), .cmd_ready(cmd_ready), .dqin(dqin), .dqout(dqout), .dq_valid(dq_valid),
    .row_open(row_open), .open_row(open_row), .cmd_err(cmd_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
    end
  endtask
  function automatic int wrapc(input int col, input int n, input int k);
    return (col & ~(n - 1)) | ((col + k) & (n - 1));
  endfunction
  always @(negedge clk) begin
    if (!reset_n) last_dq = '0;
    else begin
      if (exq.size() > 0 && exq[0].c < cyc) begin
        chk("rd_missing_beat_cycle", cyc, exq[0].c);
        void'(exq.pop_front());
      end
      if (dq_valid) begin
        if (exq.size() == 0) chk("rd_unexpected_beat", 1, 0);
        else begin
          beat_t b;
          b = exq.pop_front();
          chk("rd_cycle", cyc, b.c);
          chk("rd_data", dqout, b.d);
          last_dq = b.d;
        end
      end else chk("dq_hold", dqout, last_dq);
    end
  end
  task automatic chk_rst();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_dqout", dqout, 0);
    chk("rst_dq_valid", dq_valid, 0);
    chk("rst_row_open", row_open, 0);
    chk("rst_open_row", open_row, 0);
    chk("rst_cmd_err", cmd_err, 0);
  endtask
  // Issue one command in the current cycle and follow it to completion against the model
  task automatic op(input int c, input bit b4, input int r, input int col, input bit inj, input int abort);
    int t, n, l;
    bit err, burst;
    t = cyc;
    n = b4 ? 4 : BL;
    cmd_valid = 1'b1; cmd = 3'(c); bc4 = b4; row = 5'(r); column = 10'(col);
    err   = ((c == 3 || c == 4) && !mopen) || (c == 1 && mopen);
    burst = (c == 3 || c == 4) && mopen;
    if (c == 1 && !mopen) begin mopen = 1; morow = r; end
    if (c == 2) mopen = 0;
    if (c == 3 && burst)
      for (int k = 0; k < n; k++) exq.push_back('{t + RL + k, mm[morow * 1024 + wrapc(col, n, k)]});
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = '0;
    if (!burst) begin
      @(negedge clk);
      chk("cmd_err", cmd_err, err);
      chk("ready_after_cmd", cmd_ready, 1);
      chk("row_open", row_open, mopen);
      chk("open_row", open_row, morow);
      @(posedge clk); #1;
    end else begin
      l = c == 3 ? RL : WL;
      for (int j = 1; j <= l + n; j++) begin
        if (c == 4) dqin = (j >= WL && j < WL + n) ? wd[j - WL] : 4'($urandom);
        if (inj && j == 1) begin cmd_valid = 1'b1; cmd = 3'd4; column = 10'($urandom); end
        if (abort != 0 && j == abort) begin
          reset_n = 1'b0; mopen = 0; morow = 0; exq.delete();
          repeat (2) begin @(negedge clk); chk_rst(); end
          @(posedge clk); #1;
          reset_n = 1'b1;
          return;
        end
        if (c == 4 && j >= WL && j < WL + n) mm[morow * 1024 + wrapc(col, n, j - WL)] = wd[j - WL];
        @(negedge clk);
        chk("busy_ready", cmd_ready, j == l + n);
        chk("busy_no_err", cmd_err, 0);
        chk("busy_row_open", row_open, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = '0;
      end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      op(1, 0, r, 0, 0, 0);
      for (int b = 0; b < 16; b += 8) begin
        foreach (wd[i]) wd[i] = 4'($urandom);
        op(4, 0, 0, b, 0, 0);
      end
      op(2, 0, 0, 0, 0, 0);
    end
    wd = '{4'h3, 4'h9, 4'hD, 4'h1, 4'hD, 4'hC, 4'h6, 4'h5};
    op(1, 0, 1, 0, 0, 0);
    op(4, 0, 0, 0, 0, 0);
    op(3, 0, 0, 0, 0, 0);
    op(3, 0, 0, 5, 0, 0);
    op(3, 1, 0, 6, 0, 0);
    op(2, 0, 0, 0, 0, 0);
    op(3, 0, 0, 0, 0, 0);
    op(2, 0, 0, 0, 0, 0);
    op(1, 0, 1, 0, 0, 0);
    op(1, 0, 2, 0, 0, 0);
    op(3, 0, 0, 0, 1, 0);
    op(3, 0, 0, 0, 0, 0);
    op(2, 0, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0, 0);
    foreach (wd[i]) wd[i] = 4'hF;
    op(4, 0, 0, 0, 0, WL + 3);
    op(1, 0, 2, 0, 0, 0);
    op(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      int c;
      c = $urandom_range(0, 7);
      foreach (wd[k]) wd[k] = 4'($urandom);
      op(c, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom), 0);
    end
    repeat (RL + BL + 2) @(negedge clk);
    chk("queue_drained", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
